// File: rtl/switch_config_sequencer.sv
// Crosspoint switch configuration sequencer: buffers commands in a FIFO and
// issues reset/program operations to a switch interface with rdy handshakes.
module switch_config_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    input  logic        clear_req,
    output logic        sw_cs,
    output logic [3:0]  sw_op,
    output logic [15:0] sw_data,
    input  logic        sw_rdy,
    output logic        busy,
    output logic        err,
    output logic [7:0]  issued_count,
    output logic [2:0]  dbg_state_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0] SW_OP_RESET = 4'b0001;
    localparam logic [3:0] SW_OP_PROG  = 4'b0010;

    typedef enum logic [2:0] {
        ST_INIT, ST_CLR0, ST_CLR1, ST_IDLE, ST_ISSUE, ST_WAIT_LO, ST_WAIT_HI
    } state_e;

    typedef enum logic [1:0] {OP_CLR0, OP_CLR1, OP_PROG} op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic [7:0]      count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     sw_data_q;
    logic            sel;
    logic [3:0]      sel_op;
    logic [15:0]     sel_data;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [15:0]     fifo_head;

    // Handshake: a command is taken on every rising edge where cmd_valid and
    // cmd_ready are both high; ready ignores a same-cycle pop.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = (state_q == ST_ISSUE);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            op_q      <= OP_CLR0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            count_q   <= 8'd0;
            timer_q   <= '0;
            sw_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            sw_data_q <= sel_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        err_d    = err_q;
        pend_d   = pend_q | clear_req;
        count_d  = count_q;
        timer_d  = '0;
        sel      = 1'b0;
        sel_op   = 4'b0000;
        sel_data = sw_data_q;

        case (state_q)
            ST_INIT: state_d = ST_CLR0;
            ST_CLR0: begin
                sel      = 1'b1;
                sel_op   = SW_OP_RESET;
                sel_data = 16'h0000;
                op_d     = OP_CLR0;
                state_d  = ST_WAIT_LO;
            end
            ST_CLR1: begin
                sel      = 1'b1;
                sel_op   = SW_OP_RESET;
                sel_data = 16'h0010;
                op_d     = OP_CLR1;
                state_d  = ST_WAIT_LO;
            end
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_CLR0;
                end else if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sel      = 1'b1;
                sel_op   = SW_OP_PROG;
                sel_data = fifo_head;
                op_d     = OP_PROG;
                state_d  = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!sw_rdy) begin
                    state_d = ST_WAIT_HI;
                end else if (timer_q >= TIMER_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (sw_rdy) begin
                    case (op_q)
                        OP_CLR0: state_d = ST_CLR1;
                        OP_CLR1: begin
                            state_d = ST_IDLE;
                            err_d   = 1'b0;
                            pend_d  = 1'b0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            count_d = count_q + 8'd1;
                        end
                    endcase
                end else if (timer_q >= TIMER_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Counter is zero during the select cycle and counts wait cycles after it.
        if ((state_d == ST_WAIT_LO) || (state_d == ST_WAIT_HI)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    assign sw_cs        = sel;
    assign sw_op        = sel_op;
    assign sw_data      = sel_data;
    assign busy         = !fifo_empty || (state_q != ST_IDLE);
    assign err          = err_q;
    assign issued_count = count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_switch_config_sequencer.sv
// Directed and randomized checks of switch_config_sequencer against a
// behavioural switch and an expected-select queue.
module tb_switch_config_sequencer;

    localparam int         FIFO_DEPTH = 8;
    localparam int         TIMEOUT    = 255;
    localparam logic [3:0] OPC_RST    = 4'b0001;
    localparam logic [3:0] OPC_PRG    = 4'b0010;
    localparam int         M_NORMAL   = 0;
    localparam int         M_MANUAL   = 1;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data  = 16'h0000;
    logic        clear_req = 1'b0;
    logic        sw_rdy    = 1'b1;
    logic        cmd_ready;
    logic        sw_cs;
    logic [3:0]  sw_op;
    logic [15:0] sw_data;
    logic        busy;
    logic        err;
    logic [7:0]  issued_count;
    logic [2:0]  dbg_state;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          model_mode = M_NORMAL;
    logic        rdy_manual = 1'b1;
    logic        prev_cs    = 1'b0;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    logic [7:0]  exp_issued = 8'd0;

    switch_config_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .clear_req    (clear_req),
        .sw_cs        (sw_cs),
        .sw_op        (sw_op),
        .sw_data      (sw_data),
        .sw_rdy       (sw_rdy),
        .busy         (busy),
        .err          (err),
        .issued_count (issued_count),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Switch model: in normal mode answers each select with rdy low then high
    // after random delays; in manual mode follows rdy_manual.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (model_mode != M_NORMAL) begin
                sw_rdy = rdy_manual;
            end else if (sw_cs === 1'b1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 sw_rdy = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 sw_rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (sw_cs === 1'b1) begin
            obs_q.push_back({sw_op, sw_data});
            chk("select_width", {31'b0, prev_cs}, 32'd0);
        end
        prev_cs = sw_cs;
    end

    task automatic push(input logic [15:0] d, output bit acc);
        cmd_valid = 1'b1;
        cmd_data  = d;
        acc       = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < budget);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_sel(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sw_cs !== 1'b1 && n < budget);
        chk({tag, "_sel"}, {31'b0, sw_cs}, 32'd1);
    endtask

    task automatic cmp_phase(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            chk(tag, {12'b0, obs_q.pop_front()}, {12'b0, exp_q.pop_front()});
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic exp_clear();
        exp_q.push_back({OPC_RST, 16'h0000});
        exp_q.push_back({OPC_RST, 16'h0010});
    endtask

    bit          acc;
    int          n;
    int          tries;
    logic [15:0] d;
    logic [15:0] words[9];

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cs",    {31'b0, sw_cs}, 32'd0);
        chk("rst_op",    {28'b0, sw_op}, 32'd0);
        chk("rst_data",  {16'b0, sw_data}, 32'd0);
        chk("rst_err",   {31'b0, err}, 32'd0);
        chk("rst_count", {24'b0, issued_count}, 32'd0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Initial clear sequence
        exp_clear();
        wait_idle("init", 100);
        chk("init_err", {31'b0, err}, 32'd0);
        cmp_phase("init_seq");

        // Two directed program commands
        push(16'h0885, acc);
        chk("dir_acc0", {31'b0, acc}, 32'd1);
        push(16'h0013, acc);
        chk("dir_acc1", {31'b0, acc}, 32'd1);
        exp_q.push_back({OPC_PRG, 16'h0885});
        exp_q.push_back({OPC_PRG, 16'h0013});
        exp_issued += 8'd2;
        wait_idle("dir", 100);
        chk("dir_count", {24'b0, issued_count}, {24'b0, exp_issued});
        cmp_phase("dir_seq");

        // Stuck-high switch: timeout
        model_mode = M_MANUAL;
        rdy_manual = 1'b1;
        push(16'h1234, acc);
        wait_sel("to", 20);
        n = 0;
        while (err !== 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_err",   {31'b0, err}, 32'd1);
        chk("to_busy",  {31'b0, busy}, 32'd0);
        chk("to_count", {24'b0, issued_count}, {24'b0, exp_issued});
        exp_q.push_back({OPC_PRG, 16'h1234});
        cmp_phase("to_seq");

        // FIFO full while the switch stalls
        rdy_manual = 1'b0;
        push(16'hA001, acc);
        wait_sel("full", 20);
        exp_q.push_back({OPC_PRG, 16'hA001});
        for (int i = 0; i < 9; i++) begin
            words[i] = 16'($urandom);
            push(words[i], acc);
            chk("full_acc", {31'b0, acc}, (i < FIFO_DEPTH) ? 32'd1 : 32'd0);
            if (i < FIFO_DEPTH) exp_q.push_back({OPC_PRG, words[i]});
        end
        chk("full_ready", {31'b0, cmd_ready}, 32'd0);
        chk("full_selects", obs_q.size(), 32'd1);
        rdy_manual = 1'b1;
        @(negedge clk);
        model_mode = M_NORMAL;
        exp_issued += 8'd9;
        wait_idle("full", 400);
        chk("full_err",   {31'b0, err}, 32'd1);
        chk("full_count", {24'b0, issued_count}, {24'b0, exp_issued});
        cmp_phase("full_seq");

        // Clear request during WAIT_HI with two commands queued
        model_mode = M_MANUAL;
        rdy_manual = 1'b1;
        push(16'h0C01, acc);
        wait_sel("clr", 20);
        push(16'h0C02, acc);
        push(16'h0C03, acc);
        rdy_manual = 1'b0;
        repeat (2) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        rdy_manual = 1'b1;
        @(negedge clk);
        model_mode = M_NORMAL;
        exp_q.push_back({OPC_PRG, 16'h0C01});
        exp_clear();
        exp_q.push_back({OPC_PRG, 16'h0C02});
        exp_q.push_back({OPC_PRG, 16'h0C03});
        exp_issued += 8'd3;
        wait_idle("clr", 200);
        chk("clr_err",   {31'b0, err}, 32'd0);
        chk("clr_count", {24'b0, issued_count}, {24'b0, exp_issued});
        cmp_phase("clr_seq");

        // Random traffic, long enough to wrap issued_count
        for (int i = 0; i < 250; i++) begin
            d = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tries = 0;
            do begin
                push(d, acc);
                tries++;
            end while (!acc && tries < 200);
            chk("rand_accept", {31'b0, acc}, 32'd1);
            exp_q.push_back({OPC_PRG, d});
            exp_issued += 8'd1;
        end
        wait_idle("rand", 300);
        chk("rand_err",   {31'b0, err}, 32'd0);
        chk("rand_count", {24'b0, issued_count}, {24'b0, exp_issued});
        cmp_phase("rand_seq");

        // Reset while a command is waiting for rdy low
        model_mode = M_MANUAL;
        rdy_manual = 1'b1;
        push(16'h0E01, acc);
        wait_sel("mid", 20);
        push(16'h0E02, acc);
        push(16'h0E03, acc);
        rst_n = 1'b0;
        #1;
        chk("mid_cs",    {31'b0, sw_cs}, 32'd0);
        chk("mid_op",    {28'b0, sw_op}, 32'd0);
        chk("mid_data",  {16'b0, sw_data}, 32'd0);
        chk("mid_err",   {31'b0, err}, 32'd0);
        chk("mid_count", {24'b0, issued_count}, 32'd0);
        chk("mid_ready", {31'b0, cmd_ready}, 32'd1);
        exp_q.delete();
        obs_q.delete();
        model_mode = M_NORMAL;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_clear();
        wait_idle("mid", 100);
        chk("mid_count_after", {24'b0, issued_count}, 32'd0);
        cmp_phase("mid_seq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_config_sequencer.md
SWITCH_CONFIG_SEQUENCER -- requirements
Module: switch_config_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cmd_valid  in  1  crosspoint command offered.
REQ-004 SHALL have ports: cmd_data  in  16  command word: [3:0] X, [4] switch select, [9:7] Y, [11] on/off, other bits ignored and forwarded unchanged.
REQ-005 SHALL have ports: cmd_ready  out  1  FIFO can accept a command.
REQ-006 SHALL have ports: clear_req  in  1  one-cycle pulse requesting a reset of both switches.
REQ-007 SHALL have ports: sw_cs  out  1  chip select to the switch interface group.
REQ-008 SHALL have ports: sw_op  out  4  op to switch interface: 4'b0001 reset, 4'b0010 program.
REQ-009 SHALL have ports: sw_data  out  16  data_in to switch interface.
REQ-010 SHALL have ports: sw_rdy  in  1  rdy from switch interface.
REQ-011 SHALL have ports: busy  out  1  FIFO non-empty or FSM not in IDLE.
REQ-012 SHALL have ports: err  out  1  sticky timeout flag.
REQ-013 SHALL have ports: issued_count  out  8  count of completed program commands, wraps 255->0.
REQ-014 SHALL have parameters: FIFO_DEPTH, default 8, command FIFO depth (power of two); TIMEOUT, default 255, maximum cycles per downstream operation.

Function
REQ-015 SHALL buffer commands in a FIFO of FIFO_DEPTH 16-bit words; push when cmd_valid && cmd_ready.
REQ-016 SHALL drive cmd_ready = 0 when the FIFO is full, including cycles with a same-cycle pop; cmd_ready = 1 otherwise.
REQ-017 SHALL implement FSM states INIT, CLR0, CLR1, IDLE, ISSUE, WAIT_LO, WAIT_HI.
REQ-018 SHALL enter INIT out of reset; INIT then goes to CLR0 on the next cycle.
REQ-019 CLR0/CLR1 SHALL each: hold sw_cs = 1, sw_op = 4'b0001, sw_data[4] = 0 (CLR0) or 1 (CLR1) for exactly one cycle, then wait for sw_rdy low followed by sw_rdy high.
REQ-020 After CLR1 completes, the FSM SHALL go to IDLE, clear err, and clear the pending-clear latch.
REQ-021 clear_req SHALL set a pending-clear latch; a pulse arriving while a clear is pending is absorbed.
REQ-022 In IDLE, a pending clear SHALL take priority over the FIFO (IDLE->CLR0); otherwise a non-empty FIFO SHALL give IDLE->ISSUE.
REQ-023 In ISSUE, the FSM SHALL pop the FIFO head and hold sw_cs = 1, sw_op = 4'b0010, sw_data = head for exactly one cycle, then go to WAIT_LO.
REQ-024 WAIT_LO SHALL advance to WAIT_HI when sw_rdy = 0; WAIT_HI SHALL advance to IDLE when sw_rdy = 1, incrementing issued_count by 1 in the same cycle.
REQ-025 Outside single-cycle select cycles, sw_cs SHALL be 0, sw_op SHALL be 4'b0000, and sw_data SHALL hold its last value.
REQ-026 A cycle counter SHALL start at 0 on each select cycle; if it reaches TIMEOUT before the rdy low->high sequence completes, the FSM SHALL set err = 1, drop the operation (issued_count unchanged), and go to IDLE.
REQ-027 err SHALL remain set until a clear sequence completes; commands continue to be issued while err = 1.
REQ-028 clear_req arriving mid-command SHALL NOT abort the command; it is serviced at the next IDLE.
REQ-029 FIFO contents SHALL NOT be flushed by a clear or a timeout.

Reset
REQ-030 rst_n low SHALL asynchronously set: FSM = INIT, FIFO empty, cmd_ready = 1, sw_cs = 0, sw_op = 0, sw_data = 0, err = 0, issued_count = 0, pending-clear latch = 0, timeout counter = 0.
REQ-031 rst_n low mid-operation SHALL abandon the operation; after release, the INIT/CLR0/CLR1 sequence SHALL run before any command is issued.
REQ-032 rst_n SHALL be released synchronously to clk by the integrating level (not by this block).

Verification
REQ-033 Reset release with a behavioural switch model -> two sw_cs pulses with sw_op = 1, sw_data[4] = 0 then 1; busy falls after the second sw_rdy rise; err = 0.
REQ-034 Push 0x0885 then 0x0013 -> two program selects in order with sw_data = 0x0885 and 0x0013, each one cycle wide; issued_count = 2; busy = 0 at end.
REQ-035 Push 9 words back-to-back with sw_rdy held 0 -> cmd_ready = 0 after 8 accepted; word 9 is not stored; 1 select issued.
REQ-036 Hold sw_rdy = 1 (model stuck) after a program select -> err = 1 exactly TIMEOUT cycles after the select; FSM IDLE; issued_count unchanged.
REQ-037 clear_req during WAIT_HI with 2 commands queued -> current command completes, then CLR0/CLR1 run, then 2 commands issue; err cleared.
REQ-038 rst_n pulsed low during WAIT_LO -> all outputs at reset values immediately; the init clear sequence reruns; FIFO empty.
